jogador_automatico: RTL and testbench
=====================================

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter PRESS_CYCLES, default 4: clock cycles each replayed button is held.
REQ-002 Parameter GAP_CYCLES, default 4: clock cycles of botoes==0 after each replayed button.
REQ-003 Parameter QUIET_CYCLES, default 8: consecutive leds==0 cycles that end a capture round.
REQ-004 clock  input  1  single system clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 habilitar  input  1  level; 1 = auto-player active, 0 = forced to OCIOSO.
REQ-007 leds  input  4  game LED outputs; one-hot while a sequence item is shown.
REQ-008 ganhou  input  1  game won; 1 = stop playing.
REQ-009 perdeu  input  1  game lost; 1 = stop playing.
REQ-010 botoes  output  4  registered button drive to the game; one-hot or zero.
REQ-011 ocupado  output  1  registered; 1 in any state except OCIOSO and FIM.
REQ-012 erro_captura  output  1  registered, sticky; set on invalid LED pattern or overflow.
REQ-013 db_estado  output  4  current state code.
REQ-014 db_tamanho  output  4  captured length minus 1 (0..15) of the current/last round.

Function
REQ-015 Memory: 16 entries x 4 bits; write index and read index are 4-bit counters; tamanho is a 5-bit count (0..16).
REQ-016 States/codes: OCIOSO=0, ESPERA_LED=1, CAPTURA=2, INTERVALO=3, PRESSIONA=4, SOLTA=5, FIM=6; other codes go to OCIOSO.
REQ-017 OCIOSO: botoes=0; habilitar=1 -> ESPERA_LED with write index and tamanho cleared.
REQ-018 ESPERA_LED: leds one-hot -> write leds at index 0, tamanho=1, go CAPTURA; leds==0 -> stay.
REQ-019 CAPTURA: stays while leds equal the captured value; leds==0 -> INTERVALO with quiet counter=1.
REQ-020 INTERVALO: leds==0 increments quiet counter; counter reaching QUIET_CYCLES -> PRESSIONA with read index=0.
REQ-021 INTERVALO: leds one-hot -> write at index tamanho, tamanho+1, go CAPTURA.
REQ-022 Each LED item is recorded exactly once, in the cycle leds transition from zero to one-hot, regardless of how long it stays lit.
REQ-023 Any non-zero, non-one-hot leds in ESPERA_LED, CAPTURA or INTERVALO, or a change between two non-zero values without an intervening zero -> erro_captura=1, go FIM.
REQ-024 A 17th capture (tamanho==16 and new one-hot leds) -> erro_captura=1, go FIM; no write.
REQ-025 PRESSIONA: botoes=memory[read index] for exactly PRESS_CYCLES cycles, then SOLTA.
REQ-026 SOLTA: botoes=0 for exactly GAP_CYCLES cycles; then if read index==tamanho-1 -> ESPERA_LED with write index and tamanho cleared, else read index+1 and PRESSIONA.
REQ-027 leds are ignored in PRESSIONA and SOLTA (game echo does not capture).
REQ-028 ganhou=1 or perdeu=1 in any state other than OCIOSO -> FIM next cycle; takes priority over all other transitions except habilitar=0.
REQ-029 habilitar=0 in any state -> OCIOSO next cycle, botoes=0 that same edge; highest synchronous priority.
REQ-030 FIM: botoes=0; erro_captura held; habilitar=0 -> OCIOSO.
REQ-031 erro_captura clears only on OCIOSO->ESPERA_LED or reset.
REQ-032 botoes never has more than one bit set; botoes changes only on clock edges.

Reset
REQ-033 reset=0 asynchronously forces OCIOSO, botoes=0, ocupado=0, erro_captura=0, tamanho, indices and counters=0; memory content undefined.
REQ-034 Reset asserted mid-replay releases any held button immediately, without waiting for a clock edge.

Verification
REQ-035 habilitar=1; leds 0001 for 10 cycles, 0 for 8 -> botoes=0001 for 4 cycles, 0 for 4, then ESPERA_LED, db_tamanho=0.
REQ-036 leds 0100,0 (3 cycles),1000,0 (3 cycles),0010,0 (8 cycles) -> botoes 0100,1000,0010 each 4 cycles separated by 4 zero cycles; db_tamanho=2.
REQ-037 leds=0011 during ESPERA_LED -> erro_captura=1, db_estado=6, botoes=0; habilitar=0 -> OCIOSO, erro_captura stays 1 until habilitar=1.
REQ-038 17 valid LED items without an 8-cycle gap -> erro_captura=1, FIM, no replay.
REQ-039 perdeu=1 during PRESSIONA -> next cycle db_estado=6, botoes=0.
REQ-040 reset=0 between clock edges during PRESSIONA -> botoes=0 and db_estado=0 before the next edge.

Source files
------------

// File: rtl/jogador_automatico.sv
// jogador_automatico: plays back a memory-type game ("genius") on its own.
// It records the LED sequence the game shows, and once the LEDs have been
// dark for QUIET_CYCLES cycles it presses the recorded buttons in the same
// order. Then it goes back to waiting for the next, longer, sequence.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous, active-low
//   habilitar    1 = player active, 0 = forced to OCIOSO
//   leds[3:0]    game LEDs, one-hot while a sequence item is shown
//   ganhou       game won  -> stop
//   perdeu       game lost -> stop
//   botoes[3:0]  registered button drive (one-hot or zero)
//   ocupado      registered, 1 outside OCIOSO and FIM
//   erro_captura registered, sticky capture error flag
//   db_estado    current state code
//   db_tamanho   captured length minus 1 of the current/last round
module jogador_automatico #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       erro_captura,
  output logic [3:0] db_estado,
  output logic [3:0] db_tamanho
);

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    ESPERA_LED = 4'd1,
    CAPTURA    = 4'd2,
    INTERVALO  = 4'd3,
    PRESSIONA  = 4'd4,
    SOLTA      = 4'd5,
    FIM        = 4'd6
  } estado_t;

  estado_t     r_estado, w_prox;
  logic [3:0]  r_mem [16];
  logic [3:0]  r_wr_idx, w_wr_idx;
  logic [3:0]  r_rd_idx, w_rd_idx;
  logic [4:0]  r_tamanho, w_tamanho;
  logic [15:0] r_quieto, w_quieto;
  logic [15:0] r_cnt, w_cnt;
  logic [3:0]  r_ultimo, w_ultimo;
  logic [3:0]  r_db_tam, w_db_tam;
  logic [3:0]  r_botoes, w_botoes;
  logic        r_ocupado;
  logic        r_erro, w_erro;
  logic        w_grava;
  logic [3:0]  w_addr;
  logic        w_unico;

  assign w_unico = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);

  always_comb begin
    w_prox    = r_estado;
    w_wr_idx  = r_wr_idx;
    w_rd_idx  = r_rd_idx;
    w_tamanho = r_tamanho;
    w_quieto  = r_quieto;
    w_cnt     = r_cnt;
    w_ultimo  = r_ultimo;
    w_db_tam  = r_db_tam;
    w_erro    = r_erro;
    w_botoes  = '0;
    w_grava   = 1'b0;
    w_addr    = r_wr_idx;

    case (r_estado)
      OCIOSO: begin
        if (habilitar) begin
          w_prox    = ESPERA_LED;
          w_wr_idx  = '0;
          w_tamanho = '0;
          w_erro    = 1'b0;
        end
      end
      ESPERA_LED: begin
        if (w_unico) begin
          w_grava   = 1'b1;
          w_addr    = 4'd0;
          w_wr_idx  = 4'd1;
          w_tamanho = 5'd1;
          w_ultimo  = leds;
          w_db_tam  = 4'd0;
          w_prox    = CAPTURA;
        end else if (leds != 4'd0) begin
          w_erro = 1'b1;
          w_prox = FIM;
        end
      end
      CAPTURA: begin
        if (leds == 4'd0) begin
          w_quieto = 16'd1;
          w_prox   = INTERVALO;
        end else if (leds != r_ultimo) begin
          w_erro = 1'b1;
          w_prox = FIM;
        end
      end
      INTERVALO: begin
        if (leds == 4'd0) begin
          if (r_quieto + 16'd1 >= 16'(QUIET_CYCLES)) begin
            w_prox   = PRESSIONA;
            w_rd_idx = '0;
            w_cnt    = 16'd1;
            w_botoes = r_mem[0];
          end else begin
            w_quieto = r_quieto + 16'd1;
          end
        end else if (w_unico) begin
          if (r_tamanho == 5'd16) begin
            w_erro = 1'b1;
            w_prox = FIM;
          end else begin
            w_grava   = 1'b1;
            w_wr_idx  = r_wr_idx + 4'd1;
            w_tamanho = r_tamanho + 5'd1;
            w_ultimo  = leds;
            w_db_tam  = r_tamanho[3:0];
            w_prox    = CAPTURA;
          end
        end else begin
          w_erro = 1'b1;
          w_prox = FIM;
        end
      end
      PRESSIONA: begin
        if (r_cnt >= 16'(PRESS_CYCLES)) begin
          w_cnt  = 16'd1;
          w_prox = SOLTA;
        end else begin
          w_cnt    = r_cnt + 16'd1;
          w_botoes = r_mem[r_rd_idx];
        end
      end
      SOLTA: begin
        if (r_cnt >= 16'(GAP_CYCLES)) begin
          if ({1'b0, r_rd_idx} == r_tamanho - 5'd1) begin
            w_prox    = ESPERA_LED;
            w_wr_idx  = '0;
            w_tamanho = '0;
          end else begin
            w_rd_idx = r_rd_idx + 4'd1;
            w_cnt    = 16'd1;
            w_botoes = r_mem[r_rd_idx + 4'd1];
            w_prox   = PRESSIONA;
          end
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      FIM: begin
        if (!habilitar) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase

    // Game over wins over any capture/replay decision made above, but a
    // simultaneous bad LED pattern must not raise the error flag.
    if ((ganhou || perdeu) && r_estado != OCIOSO) begin
      w_prox   = FIM;
      w_botoes = '0;
      w_grava  = 1'b0;
      w_erro   = r_erro;
    end

    if (!habilitar) begin
      w_prox   = OCIOSO;
      w_botoes = '0;
      w_grava  = 1'b0;
      w_erro   = r_erro;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= OCIOSO;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_tamanho <= '0;
      r_quieto  <= '0;
      r_cnt     <= '0;
      r_ultimo  <= '0;
      r_db_tam  <= '0;
      r_botoes  <= '0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_wr_idx  <= w_wr_idx;
      r_rd_idx  <= w_rd_idx;
      r_tamanho <= w_tamanho;
      r_quieto  <= w_quieto;
      r_cnt     <= w_cnt;
      r_ultimo  <= w_ultimo;
      r_db_tam  <= w_db_tam;
      r_botoes  <= w_botoes;
      r_ocupado <= (w_prox != OCIOSO) && (w_prox != FIM);
      r_erro    <= w_erro;
    end
  end

  // Sequence memory has no reset; its content is only read after being written.
  always_ff @(posedge clock) begin
    if (w_grava) r_mem[w_addr] <= leds;
  end

  assign botoes       = r_botoes;
  assign ocupado      = r_ocupado;
  assign erro_captura = r_erro;
  assign db_estado    = r_estado;
  assign db_tamanho   = r_db_tam;

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;
  localparam int PRESS = 4;
  localparam int GAP   = 4;
  localparam int QUIET = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilitar = 1'b0;
  logic       ganhou = 1'b0;
  logic       perdeu = 1'b0;
  logic [3:0] leds = '0;
  logic [3:0] botoes, db_estado, db_tamanho;
  logic       ocupado, erro_captura;

  jogador_automatico #(
    .PRESS_CYCLES(PRESS),
    .GAP_CYCLES  (GAP),
    .QUIET_CYCLES(QUIET)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .habilitar   (habilitar),
    .leds        (leds),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
    .botoes      (botoes),
    .ocupado     (ocupado),
    .erro_captura(erro_captura),
    .db_estado   (db_estado),
    .db_tamanho  (db_tamanho)
  );

  always #5 clock = ~clock;

  // Expected button press: value, whether the zero gap before it must be
  // exactly GAP, and whether its length must be exactly PRESS.
  typedef struct {
    logic [3:0] val;
    bit         gap_chk;
    bit         len_chk;
  } exp_t;

  typedef struct {
    logic [3:0] val;
    int         on;
    int         off;
  } item_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, want, $time);
  endtask

  // Monitor: every press the DUT presents is popped from the scoreboard.
  bit   in_press = 1'b0;
  int   plen = 0;
  int   pgap = 0;
  exp_t cur;

  always @(negedge clock) begin
    if (!reset) begin
      in_press = 1'b0;
      pgap     = 0;
    end else if (botoes != 4'd0) begin
      if (!in_press) begin
        in_press = 1'b1;
        plen     = 1;
        check("press_onehot", 32'($onehot(botoes)), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_press", 32'(botoes), 32'd0);
          cur = '{botoes, 1'b0, 1'b0};
        end else begin
          cur = exp_q.pop_front();
          check("press_value", 32'(botoes), 32'(cur.val));
          if (cur.gap_chk) check("gap_len", pgap, GAP);
        end
      end else begin
        plen++;
        if (botoes !== cur.val) check("press_stable", 32'(botoes), 32'(cur.val));
      end
    end else begin
      if (in_press) begin
        in_press = 1'b0;
        if (cur.len_chk) check("press_len", plen, PRESS);
        pgap = 1;
      end else begin
        pgap++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input item_t its[$]);
    foreach (its[i]) begin
      leds = its[i].val;
      tick(its[i].on);
      leds = '0;
      tick(its[i].off);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int limit, input string nome);
    int k = 0;
    while (db_estado !== s && k < limit) begin
      @(negedge clock);
      k++;
    end
    check(nome, 32'(db_estado), 32'(s));
  endtask

  // One full round: capture, then replay while the LEDs carry game echo.
  task automatic run_round(input item_t its[$]);
    int n = its.size();
    foreach (its[i]) exp_q.push_back('{its[i].val, (i > 0), 1'b1});
    drive(its);
    check("replay_start", 32'(db_estado), 32'd4);
    for (int j = 0; j < (PRESS + GAP) * n - 2; j++) begin
      leds = 4'($urandom_range(0, 15));
      tick(1);
    end
    leds = '0;
    wait_state(4'd1, 20, "round_return");
    check("round_tamanho", 32'(db_tamanho), 32'(n - 1));
    check("round_erro", 32'(erro_captura), 32'd0);
    check("round_queue_empty", exp_q.size(), 32'd0);
  endtask

  function automatic logic [3:0] rand_onehot();
    logic [3:0] v = 4'b0001;
    return v << $urandom_range(0, 3);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    item_t its[$];

    #12;
    check("rst_botoes", 32'(botoes), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_erro", 32'(erro_captura), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_tamanho", 32'(db_tamanho), 32'd0);
    #4 reset = 1'b1;
    tick(2);
    check("idle_stays", 32'(db_estado), 32'd0);
    habilitar = 1'b1;
    tick(1);
    check("enable_estado", 32'(db_estado), 32'd1);
    check("enable_ocupado", 32'(ocupado), 32'd1);

    // Single long item
    its.delete();
    its.push_back('{4'b0001, 10, QUIET});
    run_round(its);

    // Three items with short gaps
    its.delete();
    its.push_back('{4'b0100, 1, 3});
    its.push_back('{4'b1000, 1, 3});
    its.push_back('{4'b0010, 1, QUIET});
    run_round(its);

    // Random rounds
    for (int r = 0; r < 6; r++) begin
      int n = (r == 5) ? 16 : int'($urandom_range(1, 16));
      its.delete();
      for (int i = 0; i < n; i++)
        its.push_back('{rand_onehot(), int'($urandom_range(1, 5)),
                        (i == n - 1) ? QUIET : int'($urandom_range(1, QUIET - 1))});
      run_round(its);
    end

    // Multi-hot LEDs while waiting
    leds = 4'b0011;
    tick(1);
    leds = '0;
    check("multihot_estado", 32'(db_estado), 32'd6);
    check("multihot_erro", 32'(erro_captura), 32'd1);
    check("multihot_botoes", 32'(botoes), 32'd0);
    check("multihot_ocupado", 32'(ocupado), 32'd0);
    habilitar = 1'b0;
    tick(1);
    check("disable_estado", 32'(db_estado), 32'd0);
    tick(2);
    check("erro_sticky_idle", 32'(erro_captura), 32'd1);
    habilitar = 1'b1;
    tick(1);
    check("reenable_estado", 32'(db_estado), 32'd1);
    check("reenable_erro", 32'(erro_captura), 32'd0);

    // Direct change between two lit values
    leds = 4'b0001;
    tick(1);
    leds = 4'b0010;
    tick(1);
    leds = '0;
    check("change_estado", 32'(db_estado), 32'd6);
    check("change_erro", 32'(erro_captura), 32'd1);
    habilitar = 1'b0;
    tick(1);
    habilitar = 1'b1;
    tick(1);

    // Game won while waiting
    ganhou = 1'b1;
    tick(1);
    check("ganhou_estado", 32'(db_estado), 32'd6);
    check("ganhou_erro", 32'(erro_captura), 32'd0);
    check("ganhou_ocupado", 32'(ocupado), 32'd0);
    ganhou = 1'b0;
    tick(1);
    check("fim_holds", 32'(db_estado), 32'd6);
    habilitar = 1'b0;
    tick(1);
    habilitar = 1'b1;
    tick(1);

    // Seventeen items without a quiet period
    its.delete();
    for (int i = 0; i < 17; i++) its.push_back('{rand_onehot(), 2, 2});
    drive(its);
    check("overflow_estado", 32'(db_estado), 32'd6);
    check("overflow_erro", 32'(erro_captura), 32'd1);
    check("overflow_tamanho", 32'(db_tamanho), 32'd15);
    tick(20);
    check("overflow_no_replay", 32'(db_estado), 32'd6);
    habilitar = 1'b0;
    tick(1);
    habilitar = 1'b1;
    tick(1);

    // Game lost while a button is held
    exp_q.push_back('{4'b1000, 1'b0, 1'b0});
    its.delete();
    its.push_back('{4'b1000, 2, QUIET});
    drive(its);
    check("perdeu_pre_estado", 32'(db_estado), 32'd4);
    perdeu = 1'b1;
    tick(1);
    check("perdeu_estado", 32'(db_estado), 32'd6);
    check("perdeu_botoes", 32'(botoes), 32'd0);
    check("perdeu_ocupado", 32'(ocupado), 32'd0);
    perdeu = 1'b0;
    habilitar = 1'b0;
    tick(1);
    habilitar = 1'b1;
    tick(1);

    // Asynchronous reset while a button is held
    exp_q.push_back('{4'b0100, 1'b0, 1'b0});
    its.delete();
    its.push_back('{4'b0100, 3, QUIET});
    drive(its);
    tick(2);
    check("areset_pre_botoes", 32'(botoes), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("areset_botoes", 32'(botoes), 32'd0);
    check("areset_estado", 32'(db_estado), 32'd0);
    check("areset_ocupado", 32'(ocupado), 32'd0);
    check("areset_tamanho", 32'(db_tamanho), 32'd0);
    #10 reset = 1'b1;
    tick(2);
    check("post_reset_estado", 32'(db_estado), 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
